mp_addsub: RTL and testbench

MP_ADDSUB -- requirements
Module: mp_addsub

---
 rtl/mp_pkg.sv | 26 ++
 rtl/mp_limb_adder.sv | 25 ++
 rtl/mp_addsub.sv | 216 +++++++++++++++++++++
 tb/tb_mp_addsub.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp_pkg
// Description : Shared mode encodings and FSM state type for mp_addsub.
// Revision    : 1.0 - initial release
// ============================================================================
package mp_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_CSUB = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sub and csub both run as A + ~B + 1.
    function automatic logic mode_is_sub(input logic [1:0] m);
        return (m == MODE_SUB) || (m == MODE_CSUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mp_limb_adder.sv
`default_nettype none
// ============================================================================
// Module      : mp_limb_adder
// Description : Combinational LIMB_W-bit adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_limb_adder
    import mp_pkg::*;
#(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] i_a,
    input  logic [LIMB_W-1:0] i_b,
    input  logic              i_cin,
    output logic [LIMB_W-1:0] o_sum,
    output logic              o_cout
);

    // One limb of the ripple: carry out lands in the extra top bit.
    always_comb begin
        {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{LIMB_W{1'b0}}, i_cin};
    end

endmodule
`default_nettype wire

// File: rtl/mp_addsub.sv
`default_nettype none
// ============================================================================
// Module      : mp_addsub
// Description : Multi-cycle add / sub / conditional-subtract, one limb per
//               cycle, LSB limb first, operands in limb shift registers.
//               Optional macro MP_ADDSUB_CSUB_EN enables true csub (mode 10);
//               without it mode 10 behaves as sub.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_addsub
    import mp_pkg::*;
#(
    parameter int OPERAND_W = 1027,
    parameter int LIMB_W    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [OPERAND_W-1:0] in_a,
    input  logic [OPERAND_W-1:0] in_b,
    output logic [OPERAND_W:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 a_lt_b,
    output logic                 csub_taken
);

    localparam int NLIMBS = (OPERAND_W + LIMB_W - 1) / LIMB_W;
    localparam int EXT_W  = NLIMBS * LIMB_W;
    localparam int CNT_W  = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NLIMBS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic                 sub_q, sub_d;
    logic [EXT_W-1:0]     a_sh_q, a_sh_d;
    logic [EXT_W-1:0]     b_sh_q, b_sh_d;
    logic [EXT_W-1:0]     sum_sh_q, sum_sh_d;
    logic [OPERAND_W:0]   result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 a_lt_b_q, a_lt_b_d;
`ifdef MP_ADDSUB_CSUB_EN
    logic                 csub_q, csub_d;
    logic [OPERAND_W-1:0] a_keep_q, a_keep_d;
    logic                 csub_taken_q, csub_taken_d;
`endif

    logic [LIMB_W-1:0]        w_limb_sum;
    logic                     w_limb_cout;
    logic [EXT_W+LIMB_W-1:0]  w_sum_cat;
    logic [EXT_W-1:0]         w_sum_next;
    logic [EXT_W:0]           w_full;
    logic                     w_borrow;
    logic [OPERAND_W:0]       w_diff_res;
    logic                     w_unused_pad;

    mp_limb_adder #(
        .LIMB_W (LIMB_W)
    ) u_limb_adder (
        .i_a    (a_sh_q[LIMB_W-1:0]),
        .i_b    (b_sh_q[LIMB_W-1:0]),
        .i_cin  (carry_q),
        .o_sum  (w_limb_sum),
        .o_cout (w_limb_cout)
    );

    // New limb enters at the top; after NLIMBS shifts the sum is in place.
    assign w_sum_cat  = {w_limb_sum, sum_sh_q};
    assign w_sum_next = w_sum_cat[EXT_W+LIMB_W-1:LIMB_W];
    assign w_full     = {w_limb_cout, w_sum_next};
    assign w_borrow   = ~w_limb_cout;
    assign w_diff_res = {w_borrow, w_full[OPERAND_W-1:0]};

    // Zero padding above OPERAND_W and the dropped low limb carry no result.
    generate
        if (EXT_W > OPERAND_W) begin : g_pad
            assign w_unused_pad = ^{w_full[EXT_W:OPERAND_W+1], sum_sh_q[LIMB_W-1:0]};
        end else begin : g_nopad
            assign w_unused_pad = ^sum_sh_q[LIMB_W-1:0];
        end
    endgenerate

    // Next-state logic: accept in IDLE, ripple one limb per RUN cycle, publish in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        a_lt_b_d = a_lt_b_q;
`ifdef MP_ADDSUB_CSUB_EN
        csub_d       = csub_q;
        a_keep_d     = a_keep_q;
        csub_taken_d = csub_taken_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    sub_d    = mode_is_sub(mode);
                    carry_d  = mode_is_sub(mode);
                    a_sh_d   = EXT_W'(in_a);
                    b_sh_d   = mode_is_sub(mode) ? ~EXT_W'(in_b) : EXT_W'(in_b);
                    sum_sh_d = '0;
`ifdef MP_ADDSUB_CSUB_EN
                    csub_d   = (mode == MODE_CSUB);
                    a_keep_d = in_a;
`endif
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> LIMB_W;
                b_sh_d   = b_sh_q >> LIMB_W;
                sum_sh_d = w_sum_next;
                carry_d  = w_limb_cout;
                if (cnt_q == LAST_LIMB) begin
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (!sub_q) begin
                        result_d = w_full[OPERAND_W:0];
                        a_lt_b_d = 1'b0;
`ifdef MP_ADDSUB_CSUB_EN
                        csub_taken_d = 1'b0;
`endif
                    end else begin
`ifdef MP_ADDSUB_CSUB_EN
                        // A < B under csub: hand back the retained A untouched.
                        if (csub_q && w_borrow) begin
                            result_d = {1'b0, a_keep_q};
                        end else begin
                            result_d = w_diff_res;
                        end
                        csub_taken_d = csub_q & ~w_borrow;
`else
                        result_d = w_diff_res;
`endif
                        a_lt_b_d = w_borrow;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset clears everything and aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_lt_b_q <= 1'b0;
`ifdef MP_ADDSUB_CSUB_EN
            csub_q       <= 1'b0;
            a_keep_q     <= '0;
            csub_taken_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            a_lt_b_q <= a_lt_b_d;
`ifdef MP_ADDSUB_CSUB_EN
            csub_q       <= csub_d;
            a_keep_q     <= a_keep_d;
            csub_taken_q <= csub_taken_d;
`endif
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign a_lt_b = a_lt_b_q;
`ifdef MP_ADDSUB_CSUB_EN
    assign csub_taken = csub_taken_q;
`else
    assign csub_taken = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_addsub
// Description : Scoreboard bench for mp_addsub over several OPERAND_W/LIMB_W
//               pairs; honours MP_ADDSUB_CSUB_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_addsub;
    import mp_pkg::*;

    localparam int NCFG = 6;
`ifdef MP_ADDSUB_CSUB_EN
    localparam bit CSUB_EN = 1'b1;
`else
    localparam bit CSUB_EN = 1'b0;
`endif

    function automatic int cfg_w(input int k);
        case (k)
            0, 1, 2: return 1027;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_l(input int k);
        case (k)
            0: return 64;
            1: return 1;
            2: return 1027;
            3: return 1;
            4: return 8;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        logic [1027:0] res;
        logic          lt;
        logic          ct;
        longint        t0;
    } exp_t;

    int     checks   = 0;
    int     errors   = 0;
    int     finished = 0;
    longint cyc      = 0;
    logic   clk      = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain-arithmetic reference: w-bit unsigned operands, (w+1)-bit result.
    function automatic exp_t ref_calc(input int w, input logic [1:0] m,
                                      input logic [1027:0] a, input logic [1027:0] b);
        exp_t e;
        logic [1028:0] mask, aa, bb, s;
        mask = (1029'(1) << w) - 1029'(1);
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, b} & mask;
        e.lt = 1'b0;
        e.ct = 1'b0;
        e.t0 = 0;
        if (m == MODE_ADD || m == MODE_RSVD) begin
            s = aa + bb;
        end else if (m == MODE_CSUB && CSUB_EN) begin
            if (aa >= bb) begin
                s    = aa - bb;
                e.ct = 1'b1;
            end else begin
                s    = aa;
                e.lt = 1'b1;
            end
        end else begin
            e.lt = (aa < bb);
            s    = ((aa - bb) & mask) | ({1028'b0, e.lt} << w);
        end
        e.res = s[1027:0];
        return e;
    endfunction

    task automatic report(input string nm, input logic [1027:0] act, input logic [1027:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got hi=%h lo=%h, required hi=%h lo=%h",
                     nm, act[1027:996], act[95:0], req[1027:996], req[95:0]);
        end
    endtask

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        localparam int W     = cfg_w(k);
        localparam int L     = cfg_l(k);
        localparam int N     = (W + L - 1) / L;
        localparam int NRAND = (N > 100) ? 6 : 120;
        localparam int KWAIT = (N >= 5) ? 4 : 0;

        logic         reset = 1'b1;
        logic         start = 1'b0;
        logic [1:0]   mode  = 2'b00;
        logic [W-1:0] a     = '0;
        logic [W-1:0] b     = '0;
        logic [W:0]   result;
        logic         busy, done, a_lt_b, csub_taken;
        logic [W-1:0] ra, rb, ones;
        exp_t         q[$];
        exp_t         mon_e;
        exp_t         last_e;

        mp_addsub #(
            .OPERAND_W (W),
            .LIMB_W    (L)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .mode       (mode),
            .in_a       (a),
            .in_b       (b),
            .result     (result),
            .busy       (busy),
            .done       (done),
            .a_lt_b     (a_lt_b),
            .csub_taken (csub_taken)
        );

        // Monitor: every done pulse is matched against the oldest expectation.
        always @(negedge clk) begin
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg%0d unexpected_done: done=1 required 0", k);
                end else begin
                    mon_e = q.pop_front();
                    report($sformatf("cfg%0d result", k), 1028'(result), mon_e.res);
                    report($sformatf("cfg%0d a_lt_b", k), 1028'(a_lt_b), 1028'(mon_e.lt));
                    report($sformatf("cfg%0d csub_taken", k), 1028'(csub_taken), 1028'(mon_e.ct));
                    report($sformatf("cfg%0d latency", k), 1028'(cyc - mon_e.t0), 1028'(N + 1));
                end
            end
        end

        task automatic issue(input logic [1:0] m, input logic [W-1:0] av,
                             input logic [W-1:0] bv, input bit expect_done);
            exp_t e;
            e    = ref_calc(W, m, 1028'(av), 1028'(bv));
            e.t0 = cyc;
            start = 1'b1;
            mode  = m;
            a     = av;
            b     = bv;
            if (expect_done) begin
                q.push_back(e);
                last_e = e;
            end
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic wait_done();
            int n;
            n = 0;
            while (done !== 1'b1 && n < N + 8) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL cfg%0d done_timeout: waited %0d cycles, required done", k, n);
            end
            @(negedge clk);
        endtask

        task automatic rand_val(output logic [W-1:0] v);
            logic [1055:0] t;
            for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
            case ($urandom_range(0, 7))
                0:       v = '0;
                1:       v = '1;
                2:       v = W'(1);
                default: v = t[W-1:0];
            endcase
        endtask

        initial begin
            ones = '1;
            repeat (3) @(negedge clk);
            report($sformatf("cfg%0d rst_result", k), 1028'(result), '0);
            report($sformatf("cfg%0d rst_busy", k), 1028'(busy), '0);
            report($sformatf("cfg%0d rst_done", k), 1028'(done), '0);
            report($sformatf("cfg%0d rst_flags", k), 1028'({a_lt_b, csub_taken}), '0);
            reset = 1'b0;
            @(negedge clk);

            // Abort an add mid-flight with reset: no done, result stays 0.
            issue(MODE_ADD, W'(1), W'(1), 1'b0);
            repeat (KWAIT) @(negedge clk);
            report($sformatf("cfg%0d abort_busy", k), 1028'(busy), 1028'(1));
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            report($sformatf("cfg%0d abort_busy_clr", k), 1028'(busy), '0);
            repeat (N + 4) @(negedge clk);
            report($sformatf("cfg%0d abort_result", k), 1028'(result), '0);

            // Directed operations.
            issue(MODE_ADD,  W'(1),   W'(1),   1'b1); wait_done();
            issue(MODE_SUB,  W'(1),   W'(1),   1'b1); wait_done();
            issue(MODE_SUB,  W'(0),   W'(1),   1'b1); wait_done();
            issue(MODE_ADD,  ones,    W'(1),   1'b1); wait_done();
            issue(MODE_RSVD, W'(200), W'(100), 1'b1); wait_done();
            issue(MODE_CSUB, W'(7),   W'(5),   1'b1); wait_done();
            issue(MODE_CSUB, W'(5),   W'(7),   1'b1); wait_done();
            issue(MODE_CSUB, W'(9),   W'(9),   1'b1); wait_done();
            repeat (2) @(negedge clk);
            report($sformatf("cfg%0d hold_result", k), 1028'(result), last_e.res);

            // Starts while busy (mid-run and in the done cycle) are ignored.
            issue(MODE_ADD, W'(3), W'(4), 1'b1);
            report($sformatf("cfg%0d busy_after_start", k), 1028'(busy), 1028'(1));
            start = 1'b1; mode = MODE_SUB; a = ones; b = W'(5);
            @(negedge clk);
            start = 1'b0;
            begin
                int n;
                n = 0;
                while (done !== 1'b1 && n < N + 8) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL cfg%0d busy_done_timeout: waited %0d, required done", k, n);
                end
            end
            report($sformatf("cfg%0d busy_in_done", k), 1028'(busy), 1028'(1));
            start = 1'b1; mode = MODE_SUB; a = W'(9); b = W'(2);
            @(negedge clk);
            start = 1'b0;
            report($sformatf("cfg%0d idle_after_done", k), 1028'(busy), '0);
            repeat (N + 4) @(negedge clk);
            report($sformatf("cfg%0d ignored_result", k), 1028'(result), last_e.res);

            // Randomised operations.
            for (int i = 0; i < NRAND; i++) begin
                rand_val(ra);
                rand_val(rb);
                if ($urandom_range(0, 5) == 0) rb = ra;
                issue(2'($urandom_range(0, 3)), ra, rb, 1'b1);
                wait_done();
            end
            report($sformatf("cfg%0d queue_empty", k), 1028'(q.size()), '0);
            finished++;
        end
    end

    initial begin
        int t;
        t = 0;
        while (finished != NCFG && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (finished != NCFG) begin
            checks++;
            errors++;
            $display("FAIL watchdog: finished=%0d required %0d", finished, NCFG);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
